// File: rtl/rr_grant_scheduler_if.sv
// Request/grant bundle between the requesters and the round-robin scheduler.
// master drives requests; slave is the scheduler that returns the grant.
interface rr_grant_scheduler_if;
  logic       enable;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  modport master (
    output enable,
    output req,
    output done,
    input  gnt,
    input  gnt_idx,
    input  gnt_valid,
    input  timeout
  );

  modport slave (
    input  enable,
    input  req,
    input  done,
    output gnt,
    output gnt_idx,
    output gnt_valid,
    output timeout
  );
endinterface

// File: rtl/rr_grant_scheduler.sv
// 8-way round-robin grant scheduler with a hold timeout.
// Grants are registered; one idle cycle always separates two grants.
module rr_grant_scheduler #(
  parameter int MAX_HOLD = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  rr_grant_scheduler_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam bit         HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [7:0] HOLD_LAST =
    (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

  state_e     state_q;
  logic [2:0] ptr_q;
  logic [7:0] hold_q;
  logic [7:0] hold_d;
  logic [7:0] gnt_q;
  logic [2:0] idx_q;
  logic       vld_q;
  logic       tmo_q;

  logic [2:0] sel_d;
  logic       sel_vld;
  logic [2:0] ptr_nxt;
  logic       hold_exp;
  logic [2:0] scan;

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = vld_q;
  assign bus.timeout   = tmo_q;

  assign hold_d   = hold_q + 8'd1;
  assign ptr_nxt  = idx_q + 3'd1;
  assign hold_exp = HOLD_EN && (hold_q == HOLD_LAST);

  // Rotating priority scan: first request at or after ptr, mod 8.
  always_comb begin
    sel_d   = ptr_q;
    sel_vld = 1'b0;
    scan    = ptr_q;
    for (int i = 0; i < 8; i++) begin
      scan = ptr_q + 3'(i);
      if (!sel_vld && bus.req[scan]) begin
        sel_vld = 1'b1;
        sel_d   = scan;
      end
    end
  end

  // Grant FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 3'd0;
      hold_q  <= 8'd0;
      gnt_q   <= 8'd0;
      idx_q   <= 3'd0;
      vld_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      tmo_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.enable && sel_vld) begin
            state_q <= BUSY;
            idx_q   <= sel_d;
            vld_q   <= 1'b1;
            gnt_q   <= 8'd1 << sel_d;
            hold_q  <= 8'd0;
          end
        end
        BUSY: begin
          if (!bus.enable) begin
            state_q <= IDLE;
            vld_q   <= 1'b0;
            gnt_q   <= 8'd0;
          end else if (bus.done || !bus.req[idx_q]) begin
            state_q <= IDLE;
            vld_q   <= 1'b0;
            gnt_q   <= 8'd0;
            ptr_q   <= ptr_nxt;
          end else if (hold_exp) begin
            state_q <= IDLE;
            vld_q   <= 1'b0;
            gnt_q   <= 8'd0;
            ptr_q   <= ptr_nxt;
            tmo_q   <= 1'b1;
          end else begin
            hold_q <= hold_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Directed bench for rr_grant_scheduler (MAX_HOLD=4).
// Driver queues per-cycle expectations; a monitor pops and compares.
module tb_rr_grant_scheduler;

  logic clk;
  logic rst_n;

  rr_grant_scheduler_if bus ();

  rr_grant_scheduler #(
    .MAX_HOLD(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  typedef struct {
    logic [7:0] g;
    logic [2:0] i;
    logic       v;
    logic       t;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   passed;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of stimulus plus the outputs required after the edge.
  task automatic cyc(
    input logic       r,
    input logic       en,
    input logic [7:0] rq,
    input logic       d,
    input logic [7:0] g,
    input logic [2:0] i,
    input logic       v,
    input logic       t,
    input string      tag
  );
    exp_t e;
    @(negedge clk);
    rst_n      = r;
    bus.enable = en;
    bus.req    = rq;
    bus.done   = d;
    e.g = g; e.i = i; e.v = v; e.t = t; e.tag = tag;
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  // Monitor: compare DUT outputs after every edge that has an expectation.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (bus.gnt === e.g && bus.gnt_idx === e.i &&
          bus.gnt_valid === e.v && bus.timeout === e.t) begin
        passed++;
      end else begin
        $display("FAIL %s: got gnt=%h idx=%0d v=%b t=%b want gnt=%h idx=%0d v=%b t=%b",
                 e.tag, bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.timeout,
                 e.g, e.i, e.v, e.t);
      end
    end
  end

  logic [7:0] rot_g [8];
  logic [2:0] rot_i [8];

  initial begin
    checks     = 0;
    passed     = 0;
    rst_n      = 1'b0;
    bus.enable = 1'b1;
    bus.req    = 8'hFF;
    bus.done   = 1'b0;
    rot_g = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    rot_i = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};

    // reset with all requests pending
    cyc(0, 1, 8'hFF, 0, 8'h00, 0, 0, 0, "rst0");
    cyc(0, 1, 8'hFF, 0, 8'h00, 0, 0, 0, "rst1");
    cyc(1, 1, 8'hFF, 0, 8'h01, 0, 1, 0, "rst_first_gnt");

    // rotation with done one cycle after each grant, wrapping 7->0
    cyc(1, 1, 8'hFF, 1, 8'h00, 0, 0, 0, "rot_rel0");
    for (int k = 0; k < 8; k++) begin
      cyc(1, 1, 8'hFF, 0, rot_g[k], rot_i[k], 1, 0, "rot_gnt");
      cyc(1, 1, 8'hFF, 1, 8'h00, rot_i[k], 0, 0, "rot_rel");
    end

    // fairness: grant 2 then ptr=3, req=05 wraps to 0, then 2
    cyc(1, 1, 8'h04, 0, 8'h04, 2, 1, 0, "fair_g2");
    cyc(1, 1, 8'h04, 1, 8'h00, 2, 0, 0, "fair_r2");
    cyc(1, 1, 8'h05, 0, 8'h01, 0, 1, 0, "fair_wrap0");
    cyc(1, 1, 8'h05, 1, 8'h00, 0, 0, 0, "fair_r0");
    cyc(1, 1, 8'h05, 0, 8'h04, 2, 1, 0, "fair_then2");
    cyc(1, 1, 8'h05, 1, 8'h00, 2, 0, 0, "fair_r2b");

    // timeout: exactly 4 grant cycles then a one-cycle pulse
    cyc(1, 1, 8'h10, 0, 8'h10, 4, 1, 0, "to_h0");
    cyc(1, 1, 8'h10, 0, 8'h10, 4, 1, 0, "to_h1");
    cyc(1, 1, 8'h10, 0, 8'h10, 4, 1, 0, "to_h2");
    cyc(1, 1, 8'h10, 0, 8'h10, 4, 1, 0, "to_h3");
    cyc(1, 1, 8'h10, 0, 8'h00, 4, 0, 1, "to_pulse");
    cyc(1, 1, 8'h10, 0, 8'h10, 4, 1, 0, "to_regnt");
    cyc(1, 1, 8'h10, 0, 8'h10, 4, 1, 0, "to2_h1");
    cyc(1, 1, 8'h10, 0, 8'h10, 4, 1, 0, "to2_h2");
    cyc(1, 1, 8'h10, 0, 8'h10, 4, 1, 0, "to2_h3");
    cyc(1, 1, 8'h10, 1, 8'h00, 4, 0, 0, "to_done_wins");

    // requester 6 drops its request -> release, ptr=7
    cyc(1, 1, 8'h40, 0, 8'h40, 6, 1, 0, "drop_g6");
    cyc(1, 1, 8'h00, 0, 8'h00, 6, 0, 0, "drop_rel");
    cyc(1, 1, 8'h81, 0, 8'h80, 7, 1, 0, "drop_ptr7");
    cyc(1, 1, 8'h81, 1, 8'h00, 7, 0, 0, "drop_r7");

    // enable withdrawn mid-grant to 5 keeps ptr at 5
    cyc(1, 1, 8'h10, 0, 8'h10, 4, 1, 0, "en_g4");
    cyc(1, 1, 8'h10, 1, 8'h00, 4, 0, 0, "en_r4");
    cyc(1, 1, 8'hFF, 0, 8'h20, 5, 1, 0, "en_g5");
    cyc(1, 0, 8'hFF, 0, 8'h00, 5, 0, 0, "en_off");
    cyc(1, 0, 8'hFF, 0, 8'h00, 5, 0, 0, "en_off_idle");
    cyc(1, 1, 8'hFF, 0, 8'h20, 5, 1, 0, "en_regnt5");
    cyc(1, 1, 8'hFF, 1, 8'h00, 5, 0, 0, "en_r5");

    // reset mid-grant at hold_cnt=2, then ptr=0 picks 7 from req=80
    cyc(1, 1, 8'hFF, 0, 8'h40, 6, 1, 0, "mr_g6");
    cyc(1, 1, 8'hFF, 0, 8'h40, 6, 1, 0, "mr_h1");
    cyc(1, 1, 8'hFF, 0, 8'h40, 6, 1, 0, "mr_h2");
    cyc(0, 1, 8'hFF, 0, 8'h00, 0, 0, 0, "mr_reset");
    cyc(1, 1, 8'h80, 0, 8'h80, 7, 1, 0, "mr_g7");
    cyc(1, 1, 8'h80, 1, 8'h00, 7, 0, 0, "mr_r7");

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
